frame_buffer_seq: RTL and testbench

- Sequencer that owns the 24-bit frame buffer ports.
- LOAD phase: assembles UART RX bytes into RGB pixels and writes them in raster order.
- PROCESS phase: streams the whole frame back out of the buffer, in raster order with coordinates, to the Sobel/processing stage over a valid/ready handshake.
- Sits between uart_rx, frame_buffer_24bit and the edge-detection pipeline. It is the only master of both buffer ports.

---
 rtl/frame_buffer_seq.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_frame_buffer_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_seq.sv
// frame_buffer_seq: sole master of the 24-bit frame buffer ports.
// LOAD assembles UART bytes (R,G,B) into pixels and writes them in raster
// order. PROCESS streams the frame back out over a valid/ready handshake
// with x/y coordinates, sof and eol markers.
// Optional build macro FB_RX_TIMEOUT_EN: discard a partial pixel after
// TIMEOUT_CYCLES idle cycles in LOAD. The port list is the same either way.
module frame_buffer_seq #(
    parameter int unsigned IMG_WIDTH      = 1280,
    parameter int unsigned IMG_HEIGHT     = 720,
    parameter int unsigned PIXEL_BITS     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT,
    localparam int unsigned AW   = $clog2(NPIX),
    localparam int unsigned XW   = $clog2(IMG_WIDTH),
    localparam int unsigned YW   = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [AW-1:0]         wr_addr,
    output logic [PIXEL_BITS-1:0] wr_data,
    output logic                  wr_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [PIXEL_BITS-1:0] rd_data,
    output logic [PIXEL_BITS-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [XW-1:0]         pix_x,
    output logic [YW-1:0]         pix_y,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  rx_overrun
);

    // Pixels are always three bytes; refuse any other configuration.
    if (PIXEL_BITS != 24 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("frame_buffer_seq: PIXEL_BITS must be 24 and TIMEOUT_CYCLES > 0");
    end

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [XW-1:0] LAST_X    = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y    = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PROCESS,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              r_q, r_d, g_q, g_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [PIXEL_BITS-1:0]   wr_data_q, wr_data_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic                    rd_inflight_q, rd_inflight_d;
    logic                    rd_done_q, rd_done_d;
    logic                    out_v_q, out_v_d;
    logic [PIXEL_BITS-1:0]   out_data_q, out_data_d;
    logic [XW-1:0]           out_x_q, out_x_d;
    logic [YW-1:0]           out_y_q, out_y_d;
    logic                    out_sof_q, out_sof_d;
    logic                    out_eol_q, out_eol_d;
    logic                    hold_v_q, hold_v_d;
    logic [PIXEL_BITS-1:0]   hold_data_q, hold_data_d;
    logic [XW-1:0]           nx_q, nx_d;
    logic [YW-1:0]           ny_q, ny_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
`ifdef FB_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           tmo_q, tmo_d;
`endif

    // Working signals of the read pipeline.
    logic                    pop;
    logic                    load_out;
    logic [PIXEL_BITS-1:0]   load_data;
    logic [1:0]              occ;

    // Next-state and datapath: FSM, byte assembly, read streaming with skid.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        r_d           = r_q;
        g_d           = g_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_inflight_d = 1'b0;
        rd_done_d     = rd_done_q;
        out_v_d       = out_v_q;
        out_data_d    = out_data_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_sof_d     = out_sof_q;
        out_eol_d     = out_eol_q;
        hold_v_d      = hold_v_q;
        hold_data_d   = hold_data_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        overrun_d     = overrun_q;
        load_out      = 1'b0;
        load_data     = rd_data;
        pop           = out_v_q & pix_ready;
        occ           = 2'(out_v_q) + 2'(hold_v_q) + 2'(rd_inflight_q);
`ifdef FB_RX_TIMEOUT_EN
        tmo_d         = '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) overrun_d = 1'b1;
                if (start && !abort) begin
                    state_d    = S_LOAD;
                    wr_addr_d  = '0;
                    byte_idx_d = '0;
                    overrun_d  = 1'b0;
                end
            end

            S_LOAD: begin
                // Advance the pixel index once its write has been presented.
                if (wr_en_q) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = S_PROCESS;
                        rd_addr_d = '0;
                        rd_done_d = 1'b0;
                        nx_d      = '0;
                        ny_d      = '0;
                        out_v_d   = 1'b0;
                        hold_v_d  = 1'b0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
                if (rx_valid) begin
                    unique case (byte_idx_q)
                        2'd0: begin
                            r_d        = rx_data;
                            byte_idx_d = 2'd1;
                        end
                        2'd1: begin
                            g_d        = rx_data;
                            byte_idx_d = 2'd2;
                        end
                        default: begin
                            wr_data_d  = {r_q, g_q, rx_data};
                            wr_en_d    = 1'b1;
                            byte_idx_d = 2'd0;
                        end
                    endcase
                end
`ifdef FB_RX_TIMEOUT_EN
                // Idle counter restarts on every byte; on expiry a partial pixel is dropped.
                if (!rx_valid) begin
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        tmo_d      = '0;
                        byte_idx_d = 2'd0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end

            S_PROCESS: begin
                if (rx_valid) overrun_d = 1'b1;
                // Issue a read only if its data is guaranteed a slot (output or hold).
                if (!rd_done_q && (occ < 2'd2 || (occ == 2'd2 && pop))) begin
                    rd_inflight_d = 1'b1;
                    if (rd_addr_q == LAST_ADDR) rd_done_d = 1'b1;
                    else                        rd_addr_d = rd_addr_q + 1'b1;
                end
                if (!out_v_q || pop) begin
                    if (hold_v_q) begin
                        load_out    = 1'b1;
                        load_data   = hold_data_q;
                        hold_v_d    = rd_inflight_q;
                        hold_data_d = rd_data;
                    end else if (rd_inflight_q) begin
                        load_out  = 1'b1;
                        load_data = rd_data;
                    end else begin
                        out_v_d = 1'b0;
                    end
                end else if (rd_inflight_q) begin
                    hold_v_d    = 1'b1;
                    hold_data_d = rd_data;
                end
                if (load_out) begin
                    out_v_d    = 1'b1;
                    out_data_d = load_data;
                    out_x_d    = nx_q;
                    out_y_d    = ny_q;
                    out_sof_d  = (nx_q == '0) && (ny_q == '0);
                    out_eol_d  = (nx_q == LAST_X);
                    if (nx_q == LAST_X) begin
                        nx_d = '0;
                        ny_d = ny_q + 1'b1;
                    end else begin
                        nx_d = nx_q + 1'b1;
                    end
                end
                if (pop && out_x_q == LAST_X && out_y_q == LAST_Y) begin
                    state_d       = S_DONE;
                    out_v_d       = 1'b0;
                    hold_v_d      = 1'b0;
                    rd_inflight_d = 1'b0;
                end
            end

            default: begin
                if (rx_valid) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // abort wins over everything, including a coincident start.
        if (abort) begin
            state_d       = S_IDLE;
            byte_idx_d    = 2'd0;
            wr_en_d       = 1'b0;
            out_v_d       = 1'b0;
            hold_v_d      = 1'b0;
            rd_inflight_d = 1'b0;
        end

        busy_d       = (state_d == S_LOAD) || (state_d == S_PROCESS);
        frame_done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: data registers are reset as well so every output reads 0 after reset; this block holds no memory array.
            state_q       <= S_IDLE;
            byte_idx_q    <= '0;
            r_q           <= '0;
            g_q           <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_inflight_q <= 1'b0;
            rd_done_q     <= 1'b0;
            out_v_q       <= 1'b0;
            out_data_q    <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_sof_q     <= 1'b0;
            out_eol_q     <= 1'b0;
            hold_v_q      <= 1'b0;
            hold_data_q   <= '0;
            nx_q          <= '0;
            ny_q          <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef FB_RX_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            r_q           <= r_d;
            g_q           <= g_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_inflight_q <= rd_inflight_d;
            rd_done_q     <= rd_done_d;
            out_v_q       <= out_v_d;
            out_data_q    <= out_data_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_sof_q     <= out_sof_d;
            out_eol_q     <= out_eol_d;
            hold_v_q      <= hold_v_d;
            hold_data_q   <= hold_data_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
`ifdef FB_RX_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign rd_addr    = rd_addr_q;
    assign pix_data   = out_data_q;
    assign pix_valid  = out_v_q;
    assign pix_x      = out_x_q;
    assign pix_y      = out_y_q;
    assign pix_sof    = out_sof_q;
    assign pix_eol    = out_eol_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_frame_buffer_seq.sv
// Directed bench for frame_buffer_seq on a 4x2 frame with a behavioural
// 1-cycle-latency buffer model.
module tb_frame_buffer_seq;

    localparam int W = 4, H = 2, N = 8, AW = 3, XW = 2, YW = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [23:0]   wr_data, pix_data;
    logic [23:0]   rd_data = 24'h0;
    logic          wr_en, pix_valid, pix_sof, pix_eol, busy, frame_done, rx_overrun;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;

    int total = 0;
    int bad   = 0;

    frame_buffer_seq #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(24), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .busy(busy), .frame_done(frame_done), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    // Frame buffer model: write port plus synchronous read.
    logic [23:0] mem [N];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // pix_ready driver: fixed level, or a fixed repeating pattern.
    logic        use_pat = 1'b0;
    logic        ready_level = 1'b1;
    logic [15:0] rdy_pat = 16'b1101_0011_1010_0110;
    int          pat_i = 0;
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (use_pat) begin
                pix_ready = rdy_pat[pat_i];
                pat_i = (pat_i + 1) % 16;
            end else begin
                pix_ready = ready_level;
            end
        end
    end

    // Monitor: records writes, handshakes, stalls and stray strobes.
    typedef struct packed { logic [AW-1:0] a; logic [23:0] d; int c; } wr_t;
    typedef struct packed { logic [23:0] d; logic [XW-1:0] x; logic [YW-1:0] y; logic sof; logic eol; int c; } px_t;
    wr_t wq[$];
    px_t pq[$];
    int  cyc = 0, fd_cnt = 0, stall_viol = 0, stall_cnt = 0, pv_idle = 0, we_idle = 0;
    logic                  prev_stall = 1'b0;
    logic [23:0]           s_data;
    logic [XW+YW+1:0]      s_meta;
    always @(posedge clk) begin
        cyc++;
        if (wr_en) wq.push_back('{a: wr_addr, d: wr_data, c: cyc});
        if (pix_valid && pix_ready) pq.push_back('{d: pix_data, x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol, c: cyc});
        if (frame_done) fd_cnt++;
        if (pix_valid && !busy) pv_idle++;
        if (wr_en && !busy) we_idle++;
        if (prev_stall && (!pix_valid || pix_data !== s_data || {pix_x, pix_y, pix_sof, pix_eol} !== s_meta))
            stall_viol++;
        prev_stall = pix_valid && !pix_ready;
        if (prev_stall) stall_cnt++;
        s_data = pix_data;
        s_meta = {pix_x, pix_y, pix_sof, pix_eol};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Sends bytes base, base+step, ... back to back.
    task automatic send_seq(input logic [7:0] base, input int cnt);
        for (int j = 0; j < cnt; j++) begin
            rx_data  = base + 8'(j);
            rx_valid = 1'b1;
            tick(1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, {31'b0, frame_done}, 32'd1);
    endtask

    // Checks the captured stream against base-byte pixel i = {b+3i, b+3i+1, b+3i+2} (step sign s).
    task automatic check_stream(input string tag, input logic [7:0] base, input bit down);
        logic [7:0] b0;
        check({tag, "_count"}, pq.size(), N);
        for (int i = 0; i < pq.size() && i < N; i++) begin
            b0 = down ? base - 8'(3 * i) : base + 8'(3 * i);
            check({tag, "_data"}, pq[i].d, down ? {b0, b0 - 8'd1, b0 - 8'd2} : {b0, b0 + 8'd1, b0 + 8'd2});
            check({tag, "_meta"}, {pq[i].x, pq[i].y, pq[i].sof, pq[i].eol},
                  {2'(i % W), 1'(i / W), i == 0, (i % W) == W - 1});
        end
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_wr_en", {31'b0, wr_en}, 0);
        check("rst_pix_valid", {31'b0, pix_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_flags", {frame_done, rx_overrun, pix_sof, pix_eol}, 0);
        check("rst_addr", {wr_addr, rd_addr}, 0);
        check("rst_pix_data", pix_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);

        // Frame 1: back-to-back bytes, pix_ready held high.
        pulse_start();
        check("start_busy", {31'b0, busy}, 1);
        send_seq(8'h01, 24);
        wait_done("f1_done");
        check("f1_busy_in_done", {31'b0, busy}, 0);
        tick(1);
        check("f1_done_pulse", {31'b0, frame_done}, 0);
        check("f1_writes", wq.size(), N);
        for (int i = 0; i < wq.size() && i < N; i++) begin
            check("f1_wr_addr", wq[i].a, i);
            check("f1_wr_data", wq[i].d, {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)});
        end
        check_stream("f1", 8'h01, 1'b0);
        if (pq.size() == N && wq.size() == N) begin
            check("f1_first_latency", pq[0].c - wq[N-1].c, 3);
            for (int i = 1; i < N; i++) check("f1_back2back", pq[i].c - pq[0].c, i);
        end else begin
            check("f1_queue_sizes", {pq.size(), wq.size()}, {N, N});
        end
        check("f1_fd_cnt", fd_cnt, 1);

        // Frame 2: bytes with idle gaps, patterned back-pressure.
        wq.delete();
        pq.delete();
        pulse_start();
        for (int j = 0; j < 24; j++) begin
            rx_data  = 8'hF0 - 8'(j);
            rx_valid = 1'b1;
            tick(1);
            rx_valid = 1'b0;
            if (j % 3 != 0) tick(j % 3);
        end
        use_pat = 1'b1;
        wait_done("f2_done");
        use_pat = 1'b0;
        tick(2);
        check_stream("f2", 8'hF0, 1'b1);
        check("f2_stall_seen", {31'b0, stall_cnt != 0}, 1);
        check("f2_stall_stable", stall_viol, 0);

        // Frame 3: stray byte while stalled in PROCESS.
        wq.delete();
        pq.delete();
        ready_level = 1'b0;
        tick(1);
        pulse_start();
        send_seq(8'h01, 24);
        tick(6);
        check("f3_stalled_valid", {31'b0, pix_valid}, 1);
        check("f3_stalled_meta", {pix_x, pix_y, pix_sof, pix_eol}, 4'b0001 << 1);
        check("f3_pre_overrun", {31'b0, rx_overrun}, 0);
        send_seq(8'h55, 1);
        tick(2);
        check("f3_overrun_set", {31'b0, rx_overrun}, 1);
        check("f3_no_write", wq.size(), N);
        ready_level = 1'b1;
        wait_done("f3_done");
        check("f3_overrun_sticky", {31'b0, rx_overrun}, 1);
        tick(1);
        pulse_start();
        check("f3_overrun_clear", {31'b0, rx_overrun}, 0);

        // Abort mid-LOAD after 5 bytes, then abort+start together.
        wq.delete();
        pq.delete();
        send_seq(8'h21, 5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_wr_en", {31'b0, wr_en}, 0);
        tick(4);
        check("abort_writes", wq.size(), 1);
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", {31'b0, busy}, 0);
        tick(2);
        check("abort_start_idle", {31'b0, busy}, 0);
        wq.delete();
        pulse_start();
        send_seq(8'h40, 24);
        wait_done("f4_done");
        tick(1);
        check("f4_writes", wq.size(), N);
        if (wq.size() == N) begin
            check("f4_first", {5'b0, wq[0].a, wq[0].d}, {8'h00, 24'h404142});
            check("f4_last", {5'b0, wq[N-1].a, wq[N-1].d}, {8'h07, 24'h555657});
        end
        check_stream("f4", 8'h40, 1'b0);

        // Partial pixel followed by a long gap.
        wq.delete();
        pq.delete();
        pulse_start();
        send_seq(8'h11, 2);
        tick(12);
        rx_data = 8'hAA; rx_valid = 1'b1; tick(1);
        rx_data = 8'hBB; tick(1);
        rx_data = 8'hCC; tick(1);
        rx_valid = 1'b0;
        tick(3);
        check("gap_writes", wq.size(), 1);
        if (wq.size() == 1) begin
            check("gap_addr", wq[0].a, 0);
`ifdef FB_RX_TIMEOUT_EN
            check("gap_data", wq[0].d, 24'hAABBCC);
`else
            check("gap_data", wq[0].d, 24'h1112AA);
`endif
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);

        check("pv_outside_busy", pv_idle, 0);
        check("we_outside_busy", we_idle, 0);
        check("frame_done_total", fd_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
